instruction_memory_loader: RTL and testbench
============================================

// Module: instruction_memory_loader
// PURPOSE
// - Write side of the instruction memory: loads a uPower program into the instruction array
//   before the core fetches from it.
// - Accepts a byte stream over a valid/ready handshake and packs 4 bytes MSB-first into 32-bit words.
// - Writes each word to consecutive word addresses starting at 0.
// - Holds the core in reset while loading; flags short, partial or overflowing programs.
// PARAMETERS
// - DEPTH   8   instruction words in the memory (addresses 0..DEPTH-1)
// - ADDR_W  3   word address width; DEPTH <= 2**ADDR_W
// PORTS
// - clk         in   1         single clock, rising edge
// - rst_n       in   1         synchronous, active-low reset
// - start       in   1         one-cycle pulse: begin a load (honoured in IDLE and DONE only)
// - byte_valid  in   1         byte_data valid
// - byte_data   in   8         program byte, MSB of each word first
// - byte_last   in   1         qualifies the final byte of the program
// - byte_ready  out  1         loader accepts a byte this cycle
// - mem_we      out  1         instruction memory write enable
// - mem_addr    out  ADDR_W    instruction word address
// - mem_wdata   out  32        instruction word
// - cpu_hold    out  1         keeps the core in reset while loading
// - done        out  1         load finished (level, held until the next start)
// - error       out  1         load ended abnormally (level, valid while done=1)
// - word_count  out  ADDR_W+1  words written in the current or last load
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0; word buffer, byte index and address cleared.
// - Reset mid-load aborts the load. Words already written stay in memory; nothing is rolled back.
// - Byte transfer happens on a clk edge where byte_valid && byte_ready.
// - byte_ready = 1 only in LOAD. byte_ready does not depend combinationally on byte_valid.
// - FSM states: IDLE, LOAD, WRITE, DONE. cpu_hold = 1 in LOAD and WRITE, 0 otherwise.
// - IDLE:
//   - start -> LOAD; clear addr, byte index, word_count, done and error.
// - LOAD:
//   - Each transfer: word <= {word[23:0], byte_data}; byte index increments modulo 4.
//   - 4th byte transfer -> WRITE; latch byte_last into last_seen.
//   - byte_last on bytes 1-3 -> DONE with error=1; the partial word is discarded, no write.
//   - start is ignored.
// - WRITE (exactly 1 cycle):
//   - mem_we=1, mem_addr=addr, mem_wdata=word.
//   - Next edge: addr++, word_count++.
//   - last_seen -> DONE, error=0.
//   - Else if word_count+1 == DEPTH -> DONE, error=1 (overflow: memory full without byte_last).
//   - Else -> LOAD.
//   - Latency: 4th byte accepted at edge N, mem_we high in cycle N+1, byte_ready low in that cycle.
// - DONE:
//   - done=1; mem_we=0; byte_ready=0.
//   - start -> LOAD with a full clear (restart). byte_valid is ignored.
// - Boundaries:
//   - byte_last on the 4th byte of word DEPTH-1 is a normal, error-free finish.
//   - A zero-byte program cannot finish without byte_last; the bench drives byte_last.
//   - mem_addr never exceeds DEPTH-1.
//   - mem_addr/mem_wdata are don't-care when mem_we=0 but are driven from registers (no X).
// - All outputs are decoded from registered state.
// - word_count width covers the value DEPTH.
// STRUCTURE
// - Shared header upower_defs.vh holds:
//   - state encodings LDR_IDLE/LDR_LOAD/LDR_WRITE/LDR_DONE (2-bit)
//   - BYTES_PER_WORD=4
//   - INSTR_W=32
// - One natural sub-module: byte_word_packer.
//   - Contents: shift register plus modulo-4 byte index.
//   - Ports: clk, rst_n, clear, shift_en, byte_in; outputs word_out, word_full.
// - FSM, address counter and error logic stay in the top.
// TESTING
// 1. Reset then start. Stream 8 bytes 00 11 22 33 44 55 66 77, byte_last on 77
//    -> two writes: addr0=0x00112233, addr1=0x44556677; done=1, error=0, word_count=2.
// 2. Handshake and latency. byte_valid toggled randomly during the load
//    -> no byte lost or duplicated; mem_we exactly 1 cycle after each 4th accepted byte;
//       byte_ready=0 during WRITE.
// 3. Partial word. 6 bytes AA BB CC DD EE FF, byte_last on FF
//    -> one write 0xAABBCCDD; done=1, error=1, word_count=1.
// 4. Overflow. DEPTH=8, stream 36 bytes, no byte_last
//    -> 8 writes at addrs 0..7; done=1, error=1, word_count=8; the 33rd byte is never accepted.
// 5. Exact fill. 32 bytes with byte_last on the 32nd
//    -> 8 writes, error=0, word_count=8.
// 6. Reset mid-load. rst_n=0 after 5 bytes (1 word written)
//    -> next cycle: state IDLE, all outputs 0. A new start reloads from addr 0.
//    Also: start during LOAD has no effect; start in DONE restarts the load.

Source files
------------

// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encodings,
// word geometry and the byte-index helper used by the packer.
package instruction_memory_loader_pkg;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_LOAD  = 2'd1,
    LDR_WRITE = 2'd2,
    LDR_DONE  = 2'd3
  } ldr_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 32;
  localparam int BYTE_W         = 8;
  localparam int BIDX_W         = 2;

  // Byte index wraps naturally modulo BYTES_PER_WORD because BIDX_W is exactly log2 of it.
  function automatic logic [BIDX_W-1:0] bidx_next(input logic [BIDX_W-1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/instruction_memory_loader_byte_word_packer.sv
// Shift register that assembles bytes MSB-first into a 32-bit instruction word,
// with a modulo-4 byte index that tells the loader when a word completes.
module byte_word_packer
  import instruction_memory_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word_out,
  output logic               word_full
);

  logic [INSTR_W-1:0] word_r;
  logic [BIDX_W-1:0]  idx_r;

  // Shift each accepted byte into the low end so the first byte ends up in bits 31:24.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_r <= {INSTR_W{1'b0}};
      idx_r  <= {BIDX_W{1'b0}};
    end else if (clear) begin
      word_r <= {INSTR_W{1'b0}};
      idx_r  <= {BIDX_W{1'b0}};
    end else if (shift_en) begin
      word_r <= {word_r[INSTR_W-BYTE_W-1:0], byte_in};
      idx_r  <= bidx_next(idx_r);
    end else begin
      word_r <= word_r;
      idx_r  <= idx_r;
    end
  end

  assign word_out  = word_r;
  // High while three bytes are held: the next shift completes the word.
  assign word_full = (idx_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_memory_loader.sv
// Write side of the instruction memory: packs a byte stream into words, writes
// them from address 0 upward, holds the core in reset and reports how the load ended.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_count
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  ldr_state_t         state_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W:0]    word_count_r;
  logic               last_seen_r;
  logic               byte_ready_r;
  logic               mem_we_r;
  logic               cpu_hold_r;
  logic               done_r;
  logic               error_r;

  logic               xfer_s;
  logic               clear_s;
  logic               word_full_s;
  logic [INSTR_W-1:0] word_s;

  assign xfer_s  = byte_valid && byte_ready_r;
  assign clear_s = start && ((state_r == LDR_IDLE) || (state_r == LDR_DONE));

  byte_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_s),
    .shift_en  (xfer_s),
    .byte_in   (byte_data),
    .word_out  (word_s),
    .word_full (word_full_s)
  );

  // Loader FSM with address/count bookkeeping; every output is set here so it comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= LDR_IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      word_count_r <= {(ADDR_W+1){1'b0}};
      last_seen_r  <= 1'b0;
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      cpu_hold_r   <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      case (state_r)
        LDR_IDLE, LDR_DONE: begin
          if (start) begin
            state_r      <= LDR_LOAD;
            addr_r       <= {ADDR_W{1'b0}};
            word_count_r <= {(ADDR_W+1){1'b0}};
            last_seen_r  <= 1'b0;
            byte_ready_r <= 1'b1;
            mem_we_r     <= 1'b0;
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        LDR_LOAD: begin
          if (xfer_s && word_full_s) begin
            state_r      <= LDR_WRITE;
            last_seen_r  <= byte_last;
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b1;
          end else if (xfer_s && byte_last) begin
            // Program ended mid-word: drop the partial word and report it.
            state_r      <= LDR_DONE;
            byte_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b1;
            error_r      <= 1'b1;
          end else begin
            state_r <= LDR_LOAD;
          end
        end
        LDR_WRITE: begin
          mem_we_r     <= 1'b0;
          word_count_r <= word_count_r + WC_ONE;
          addr_r       <= (addr_r == ADDR_MAX) ? addr_r : addr_r + ADDR_ONE;
          if (last_seen_r) begin
            state_r    <= LDR_DONE;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b1;
            error_r    <= 1'b0;
          end else if ((word_count_r + WC_ONE) == DEPTH_C) begin
            // Memory full and the stream still has not signalled its end.
            state_r    <= LDR_DONE;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b1;
            error_r    <= 1'b1;
          end else begin
            state_r      <= LDR_LOAD;
            byte_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= LDR_IDLE;
          byte_ready_r <= 1'b0;
          mem_we_r     <= 1'b0;
          cpu_hold_r   <= 1'b0;
          done_r       <= 1'b0;
          error_r      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = word_s;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized self-checking bench for instruction_memory_loader: byte programs with
// random valid gaps, checked against a program-level model of the expected writes.
module tb_instruction_memory_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] prog_q[$];
  int         last_idx;

  instruction_memory_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prog_word(input int k);
    if (4*k + 3 < prog_q.size())
      return {prog_q[4*k], prog_q[4*k+1], prog_q[4*k+2], prog_q[4*k+3]};
    else
      return 32'h0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"},
              {byte_ready, mem_we, cpu_hold, done, error, 27'd0}, 32'h0);
    check_val({tag, "_wcnt"}, 32'(word_count), 32'h0);
    check_val({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check_val({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  // Runs one load of prog_q from IDLE or DONE; vprob is the percent chance byte_valid is high.
  task automatic run_load(input string name, input int vprob);
    int exp_words, exp_accept, idx, nwr, pend, cyc;
    logic exp_err, fin;
    // Program-level model: what the stream should produce.
    exp_words = 0; exp_accept = 0; exp_err = 1'b1;
    for (int i = 0; i < prog_q.size(); i++) begin
      exp_accept = i + 1;
      if ((i % 4) == 3) exp_words++;
      if (i == last_idx) begin
        exp_err = ((i % 4) != 3);
        break;
      end
      if (exp_words == DEPTH) break;
    end

    @(negedge clk);
    start = 1'b1; byte_valid = 1'b0; byte_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; nwr = 0; pend = -1; cyc = 0; fin = 1'b0;
    while (cyc < 3000) begin
      if (done) begin
        fin = 1'b1;
        break;
      end
      check_val({name, "_hold"}, 32'(cpu_hold), 32'h1);
      check_val({name, "_we_timing"}, 32'(mem_we), 32'(pend == cyc));
      if (mem_we) begin
        check_val({name, "_ready_in_write"}, 32'(byte_ready), 32'h0);
        check_val({name, "_addr"}, 32'(mem_addr), 32'(nwr));
        check_val({name, "_wdata"}, mem_wdata, prog_word(nwr));
        nwr++;
      end
      byte_valid = (idx < prog_q.size()) && ($urandom_range(99, 0) < vprob);
      byte_data  = byte_valid ? prog_q[idx] : 8'($urandom);
      byte_last  = byte_valid && (idx == last_idx);
      start      = ($urandom_range(15, 0) == 0);
      if (byte_valid && byte_ready) begin
        if ((idx % 4) == 3) pend = cyc + 1;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0;
    check_val({name, "_finished"}, 32'(fin), 32'h1);
    check_val({name, "_done"}, 32'(done), 32'h1);
    check_val({name, "_error"}, 32'(error), 32'(exp_err));
    check_val({name, "_word_count"}, 32'(word_count), 32'(exp_words));
    check_val({name, "_writes"}, 32'(nwr), 32'(exp_words));
    check_val({name, "_accepted"}, 32'(idx), 32'(exp_accept));
    check_val({name, "_idle_outs"}, {cpu_hold, byte_ready, mem_we, 29'd0}, 32'h0);
  endtask

  task automatic make_seq(input int n, input logic [7:0] base, input logic [7:0] step, input int last);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(8'(base + 8'(i) * step));
    last_idx = last;
  endtask

  task automatic make_rand(input int n, input int last);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
    last_idx = last;
  endtask

  initial begin
    int idx, n;
    logic seen_we;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    make_seq(8, 8'h00, 8'h11, 7);
    run_load("basic", 100);
    make_seq(8, 8'h00, 8'h11, 7);
    run_load("handshake", 50);
    make_seq(6, 8'hAA, 8'h11, 5);
    run_load("partial", 60);
    make_rand(36, -1);
    run_load("overflow", 70);
    make_rand(32, 31);
    run_load("exact_fill", 40);

    // Abort a load after five accepted bytes (one word written).
    make_seq(12, 8'h10, 8'h01, 11);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; idx = 0; n = 0; seen_we = 1'b0;
    while (idx < 5 && n < 100) begin
      if (mem_we) seen_we = 1'b1;
      byte_valid = 1'b1; byte_data = prog_q[idx]; byte_last = 1'b0;
      if (byte_ready) idx++;
      @(negedge clk);
      n++;
    end
    byte_valid = 1'b0;
    check_val("midload_accepted", 32'(idx), 32'd5);
    check_val("midload_word_written", 32'(seen_we), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midload_reset");
    rst_n = 1'b1;
    run_load("reload", 80);

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(3, 0) == 0) begin
        n = $urandom_range(40, 33);
        make_rand(n, -1);
      end else begin
        n = $urandom_range(36, 1);
        make_rand(n, n - 1);
      end
      run_load($sformatf("rand%0d", t), $urandom_range(100, 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
